alu_exec: RTL and testbench
===========================

# alu_exec

Registered execution unit that consumes the 6-bit ALU operation code from the ALU control decoder and produces the datapath result. Single-cycle ops (add, sub, and, or, slt) complete with one registered cycle of latency. Multiply runs as a 32-iteration shift-add sequence under a valid/ready handshake. Sits in the EX stage between the register-file operand muxes and the writeback/memory-address path.

## Interface
- `WIDTH`, default 32: operand/result width; multiplier iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `op_valid` input 1: operation and operands present this cycle.
- `op_ready` output 1: unit can accept an op this cycle.
- `operation` input 6: op code; 27 ADD, 28 SUB, 29 AND, 30 OR, 31 SLT, 32 MUL.
- `src_a` input WIDTH: operand A.
- `src_b` input WIDTH: operand B.
- `res_valid` output 1: one-cycle pulse; `result`/`zero`/`illegal` are valid this cycle.
- `result` output WIDTH: registered result.
- `zero` output 1: registered (`result` == 0).
- `illegal` output 1: the op code was outside the supported set.

## Operation
- Accept = `op_valid` && `op_ready`, sampled at the rising edge. Inputs are ignored when not accepted.
- FSM states:
  - IDLE: `op_ready`=1.
  - MUL: `op_ready`=0.
- Transitions:
  - IDLE to MUL: accept with op 32.
  - MUL to IDLE: at the edge where the iteration counter equals `WIDTH`-1.
  - All other accepts stay in IDLE.
- ADD/SUB: modulo 2^WIDTH; no carry or overflow output.
- AND/OR: bitwise.
- SLT: signed two's-complement compare; `result` = 1 if A<B, else 0.
- MUL: low `WIDTH` bits of the unsigned product.
  - Each MUL cycle: if multiplier bit0 = 1, add the multiplicand into the accumulator; shift the multiplicand left 1 and the multiplier right 1.
  - Operands are latched at accept; later input changes have no effect.
- Unsupported codes (0–26, 33–63): `result`=0, `zero`=1, `illegal`=1, single-cycle timing.
- `illegal`=0 for every supported op.
- No backpressure on the result side: `res_valid` is a pulse and is never held.

## Timing
- Reset values: `op_ready`=1, `res_valid`=0, `result`=0, `zero`=0, `illegal`=0, FSM=IDLE, counter=0.
- Single-cycle op accepted at edge N: `res_valid`=1 in the cycle after edge N, low after edge N+1 unless another op is accepted at N+1.
- Back-to-back single-cycle ops can be accepted every cycle, giving one result per cycle.
- MUL accepted at edge N:
  - `op_ready` is low from after edge N until after edge N+`WIDTH`.
  - `res_valid` pulses in the cycle after edge N+`WIDTH`, i.e. 32 cycles of latency at the default width.
  - `op_ready` returns high in that same cycle, so a new op can be accepted at edge N+`WIDTH`+1.
- Outputs hold their last value between pulses.
- `rst` asserted mid-MUL: immediate abort; no `res_valid` for the aborted op; IDLE after release.

## Configuration
- `ALU_MUL_EN` defined: MUL state, counter, and multiplier are compiled in, as described above.
- `ALU_MUL_EN` undefined:
  - Op 32 is treated as unsupported (`illegal`=1, `result`=0, single cycle).
  - `op_ready` is tied to 1 and no MUL state exists.

## Structure
- Package `alu_pkg` holds:
  - Op code localparams `OP_ADD`=6'd27, `OP_SUB`=28, `OP_AND`=29, `OP_OR`=30, `OP_SLT`=31, `OP_MUL`=32, shared with the ALU control decoder.
  - FSM state enum (IDLE, MUL).
- Sub-module `alu_mul_seq`:
  - Contents: shift-add datapath and iteration counter.
  - Interface: `start`, `a`, `b`, `done`, `product`.
  - Instantiated only under `ALU_MUL_EN`.
- The top level holds the handshake, the single-cycle ops, and the output registers.

## Test plan
- Reset then idle: `op_ready`=1, `res_valid`=0, `result`=0.
- ADD 7+5 at edge N: `result`=12, `zero`=0, `res_valid` pulse after N. Then SUB 5−5 at N+1: `result`=0, `zero`=1 after N+1.
- SLT with A=0xFFFFFFFF (−1), B=1: `result`=1. Swapped operands: `result`=0.
- MUL 0x10000×0x10001: `result`=0x00010000 (low 32 bits). `op_ready` low for exactly 32 cycles; `res_valid` is asserted in the cycle after edge N+32. Any `op_valid` during MUL is ignored.
- Op code 20 with any operands: `illegal`=1, `result`=0, one-cycle latency. Without `ALU_MUL_EN`, op 32 gives the same response.
- Assert `rst` at iteration 10 of a MUL: no `res_valid`; after release, an ADD 1+1 returns 2 with normal latency.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the EX-stage execution unit (alu_exec) and the ALU
// control decoder that produces its 6-bit operation codes.
//   OP_*     : operation codes understood by alu_exec
//   state_e  : alu_exec control FSM states (ST_MUL exists only with ALU_MUL_EN)
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'd27;
  localparam logic [5:0] OP_SUB = 6'd28;
  localparam logic [5:0] OP_AND = 6'd29;
  localparam logic [5:0] OP_OR  = 6'd30;
  localparam logic [5:0] OP_SLT = 6'd31;
  localparam logic [5:0] OP_MUL = 6'd32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage : alu_pkg

// File: rtl/alu_exec_if.sv
// -----------------------------------------------------------------------------
// alu_exec_if
// Operation/result bundle between the EX-stage operand muxes and alu_exec.
//   op_valid, operation, src_a, src_b : request, driven by the master
//   op_ready                           : unit can accept a request this cycle
//   res_valid, result, zero, illegal   : one-cycle result pulse and its data
// Modports: master (issuing side), slave (alu_exec).
// -----------------------------------------------------------------------------
interface alu_exec_if #(
  parameter int WIDTH = 32
);

  logic             op_valid;
  logic             op_ready;
  logic [5:0]       operation;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             res_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output op_valid, operation, src_a, src_b,
    input  op_ready, res_valid, result, zero, illegal
  );

  modport slave (
    input  op_valid, operation, src_a, src_b,
    output op_ready, res_valid, result, zero, illegal
  );

endinterface : alu_exec_if

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Shift-add multiplier producing the low WIDTH bits of the unsigned product of
// a and b in WIDTH iterations, one per clock.
//   clk, rst : clock, asynchronous active-high reset (aborts a running multiply)
//   start    : latch a/b and begin; ignored-safe only when not busy
//   a, b     : multiplicand, multiplier (sampled only with start)
//   done     : high in the cycle whose rising edge completes the last iteration
//   product  : final product, valid while done is high
// -----------------------------------------------------------------------------
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Accumulator after the current iteration; on the last iteration this is
  // the finished product, so the top can register it at the same edge.
  assign acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign done    = busy_q && (cnt_q == LAST_ITER);
  assign product = acc_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would chain updates within a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (cnt_q == LAST_ITER) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule : alu_mul_seq

// File: rtl/alu_exec.sv
// -----------------------------------------------------------------------------
// alu_exec
// Registered EX-stage execution unit. ADD/SUB/AND/OR/SLT complete with one
// registered cycle of latency; MUL (only with `ALU_MUL_EN defined) runs a
// WIDTH-cycle shift-add sequence during which op_ready is low. Unsupported
// codes return result=0, zero=1, illegal=1 with single-cycle timing.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_exec_if.slave (op_valid/op_ready/operation/src_a/src_b in,
//          res_valid/result/zero/illegal out)
// Configuration macro: ALU_MUL_EN (compiles in the MUL state and multiplier;
// without it op 32 is unsupported and op_ready is tied high).
// -----------------------------------------------------------------------------
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_exec_if.slave bus
);

  logic             accept;
  logic [WIDTH-1:0] single_res;
  logic             single_ok;

  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
  logic             illegal_q,   illegal_d;

  assign accept = bus.op_valid && bus.op_ready;

  // Single-cycle datapath; single_ok drops for any code it does not handle,
  // which is what flags the op as illegal (MUL is caught before this is used).
  // NOTE: every variable written in an always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    single_res = '0;
    single_ok  = 1'b1;
    case (bus.operation)
      OP_ADD:  single_res = bus.src_a + bus.src_b;
      OP_SUB:  single_res = bus.src_a - bus.src_b;
      OP_AND:  single_res = bus.src_a & bus.src_b;
      OP_OR:   single_res = bus.src_a | bus.src_b;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}},
                             ($signed(bus.src_a) < $signed(bus.src_b))};
      default: single_ok  = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  state_e           state_q, state_d;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .WIDTH (WIDTH)
  ) u_mul_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.src_a),
    .b       (bus.src_b),
    .done    (mul_done),
    .product (mul_product)
  );

  assign bus.op_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    mul_start   = 1'b0;
    res_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.operation == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            res_valid_d = 1'b1;
            result_d    = single_res;
            zero_d      = (single_res == '0);
            illegal_d   = ~single_ok;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b1;
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          illegal_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end
`else
  assign bus.op_ready = 1'b1;

  // Without the multiplier, op 32 falls into the unsupported path above.
  always_comb begin
    res_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;
    if (accept) begin
      res_valid_d = 1'b1;
      result_d    = single_res;
      zero_d      = (single_res == '0);
      illegal_d   = ~single_ok;
    end
  end
`endif

  // Result registers hold their value between pulses; only res_valid clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule : alu_exec

// File: tb/tb_alu_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_exec
// Directed self-checking bench for alu_exec. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the rising edge. The MUL checks
// are compiled when ALU_MUL_EN is defined; otherwise op 32 is checked as an
// unsupported code.
// -----------------------------------------------------------------------------
module tb_alu_exec;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;

  int n_checks;
  int n_fail;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_exec #(
    .WIDTH (WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present an op at the falling edge, return 1 unit after the accepting edge.
  task automatic issue(input logic [5:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.op_valid  = 1'b1;
    bus.operation = op;
    bus.src_a     = a;
    bus.src_b     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.op_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Check a full result triple right after the accepting edge.
  task automatic check_res(input string tag, input logic [WIDTH-1:0] exp_res,
                           input logic exp_zero, input logic exp_ill);
    check({tag, ".valid"},   64'(bus.res_valid), 64'd1);
    check({tag, ".result"},  64'(bus.result),    64'(exp_res));
    check({tag, ".zero"},    64'(bus.zero),      64'(exp_zero));
    check({tag, ".illegal"}, 64'(bus.illegal),   64'(exp_ill));
  endtask

`ifdef ALU_MUL_EN
  // Issue a MUL, keep a conflicting ADD on the bus while busy, and measure the
  // number of samples with op_ready low up to the result pulse.
  task automatic run_mul(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] exp_res);
    int busy_cycles;
    bit seen;
    issue(OP_MUL, a, b);
    check({tag, ".ready_low"}, 64'(bus.op_ready),  64'd0);
    check({tag, ".no_early"},  64'(bus.res_valid), 64'd0);
    busy_cycles = 1;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      bus.op_valid  = 1'b1;
      bus.operation = OP_ADD;
      bus.src_a     = $urandom;
      bus.src_b     = $urandom;
      @(posedge clk);
      #1;
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
      if (bus.op_ready) busy_cycles = busy_cycles + 100;
      busy_cycles++;
    end
    check({tag, ".pulse_seen"},  64'(seen),          64'd1);
    check({tag, ".busy_cycles"}, 64'(busy_cycles),   64'(WIDTH));
    check_res(tag, exp_res, (exp_res == '0), 1'b0);
    check({tag, ".ready_back"},  64'(bus.op_ready),  64'd1);
    idle_cycle();
    check({tag, ".single_pulse"}, 64'(bus.res_valid), 64'd0);
  endtask
`endif

  initial begin
    int pulses;
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.operation = '0;
    bus.src_a     = '0;
    bus.src_b     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.op_ready",  64'(bus.op_ready),  64'd1);
    check("rst.res_valid", 64'(bus.res_valid), 64'd0);
    check("rst.result",    64'(bus.result),    64'd0);
    check("rst.zero",      64'(bus.zero),      64'd0);
    check("rst.illegal",   64'(bus.illegal),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();
    check("idle.res_valid", 64'(bus.res_valid), 64'd0);
    check("idle.op_ready",  64'(bus.op_ready),  64'd1);

    // ADD then SUB back-to-back, one result per cycle
    issue(OP_ADD, 32'd7, 32'd5);
    check_res("add7p5", 32'd12, 1'b0, 1'b0);
    issue(OP_SUB, 32'd5, 32'd5);
    check_res("sub5m5", 32'd0, 1'b1, 1'b0);
    idle_cycle();
    check("pulse.drop", 64'(bus.res_valid), 64'd0);
    check("hold.result", 64'(bus.result),   64'd0);
    check("hold.zero",   64'(bus.zero),     64'd1);

    // Bitwise and wrap-around
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    check_res("and", 32'h00F0_1200, 1'b0, 1'b0);
    issue(OP_OR,  32'hF0F0_1234, 32'h0FF0_FF00);
    check_res("or",  32'hFFF0_FF34, 1'b0, 1'b0);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'd1);
    check_res("add_wrap", 32'd0, 1'b1, 1'b0);
    issue(OP_SUB, 32'd0, 32'd1);
    check_res("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Signed compare
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1);
    check_res("slt_neg_lt", 32'd1, 1'b0, 1'b0);
    issue(OP_SLT, 32'd1, 32'hFFFF_FFFF);
    check_res("slt_swap", 32'd0, 1'b1, 1'b0);
    issue(OP_SLT, 32'h7FFF_FFFF, 32'h8000_0000);
    check_res("slt_extremes", 32'd0, 1'b1, 1'b0);
    issue(OP_SLT, 32'd5, 32'd6);
    check_res("slt_pos", 32'd1, 1'b0, 1'b0);

    // Unsupported codes, both boundaries of the supported range
    issue(6'd20, 32'h1234_5678, 32'h9ABC_DEF0);
    check_res("op20", 32'd0, 1'b1, 1'b1);
    issue(6'd26, 32'd3, 32'd4);
    check_res("op26", 32'd0, 1'b1, 1'b1);
    issue(6'd33, 32'd3, 32'd4);
    check_res("op33", 32'd0, 1'b1, 1'b1);
    issue(OP_ADD, 32'd3, 32'd4);
    check_res("legal_after_illegal", 32'd7, 1'b0, 1'b0);
    idle_cycle();

`ifdef ALU_MUL_EN
    run_mul("mul_hi", 32'h0001_0000, 32'h0001_0001, 32'h0001_0000);
    run_mul("mul_small", 32'd1234, 32'd5678, 32'd7006652);
    run_mul("mul_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_mul("mul_zero", 32'hDEAD_BEEF, 32'd0, 32'd0);

    // Reset during iteration 10: the op is dropped without a pulse
    issue(OP_MUL, 32'd3, 32'd5);
    idle_cycle();
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.op_ready",  64'(bus.op_ready),  64'd1);
    check("abort.res_valid", 64'(bus.res_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.res_valid) pulses++;
    end
    check("abort.no_pulse", 64'(pulses), 64'd0);
`else
    // Op 32 is unsupported in this build
    issue(OP_MUL, 32'h0001_0000, 32'h0001_0001);
    check_res("mul_off", 32'd0, 1'b1, 1'b1);
    check("mul_off.op_ready", 64'(bus.op_ready), 64'd1);
    issue(OP_ADD, 32'd9, 32'd9);
    check_res("after_mul_off", 32'd18, 1'b0, 1'b0);
    idle_cycle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst2.res_valid", 64'(bus.res_valid), 64'd0);
    check("rst2.result",    64'(bus.result),    64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    // Normal operation after reset release
    issue(OP_ADD, 32'd1, 32'd1);
    check_res("post_rst_add", 32'd2, 1'b0, 1'b0);
    idle_cycle();
    check("post_rst.drop", 64'(bus.res_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Global time limit so a stuck design still produces a summary.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_alu_exec
